// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
//
// Shares one combinational RV32 ALU between two requesters. Requester 0 is the
// core execute path, requester 1 the debug/self-test port. Each side has a
// valid/ready request channel and a valid/ready response channel. Arbitration
// is round-robin. Operands are registered onto the ALU for EXEC_CYCLES cycles,
// then the ALU output is captured into the owner's response register.
//
// Parameters:
//   WIDTH        operand/result width
//   EXEC_CYCLES  cycles the operands are held on the ALU before sampling (1..15)
//
// Ports:
//   clk, rst_n                          clock, asynchronous active-low reset
//   reqN_valid/ready/a/b/op             request channel of requester N
//   rspN_valid/ready/result/zero        response channel of requester N
//   alu_srca/srcb/ctrl (out)            registered operands to the shared ALU
//   alu_result/zero (in)                combinational ALU outputs
//   busy                                high whenever the block is not idle
//   owner                               requester currently/last granted

module alu_share_arbiter #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned EXEC_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [2:0]       req0_op,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [2:0]       req1_op,

    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic [WIDTH-1:0] rsp0_result,
    output logic             rsp0_zero,

    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp1_result,
    output logic             rsp1_zero,

    output logic [WIDTH-1:0] alu_srca,
    output logic [WIDTH-1:0] alu_srcb,
    output logic [2:0]       alu_ctrl,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero,

    output logic             busy,
    output logic             owner
);

    typedef enum logic [1:0] {
        StIdle,
        StExec,
        StResp
    } state_e;

    // Counter is loaded with EXEC_CYCLES-1; sampling happens when it reaches 0.
    localparam logic [3:0] CntInit = 4'(EXEC_CYCLES - 1);

    state_e           state_q, state_d;
    logic             last_grant_q, last_grant_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] srca_q, srca_d;
    logic [WIDTH-1:0] srcb_q, srcb_d;
    logic [2:0]       ctrl_q, ctrl_d;
    logic             owner_q, owner_d;
    logic [WIDTH-1:0] rsp0_result_q, rsp0_result_d;
    logic             rsp0_zero_q, rsp0_zero_d;
    logic [WIDTH-1:0] rsp1_result_q, rsp1_result_d;
    logic             rsp1_zero_q, rsp1_zero_d;

    logic idle;
    logic grant;

    assign idle = (state_q == StIdle);

    // With both requesting, the side that did not win last time gets the slot.
    always_comb begin
        if (req0_valid && req1_valid) begin
            grant = ~last_grant_q;
        end else begin
            grant = req1_valid;
        end
    end

    assign req0_ready = idle && req0_valid && !grant;
    assign req1_ready = idle && req1_valid && grant;

    always_comb begin
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        cnt_d         = cnt_q;
        srca_d        = srca_q;
        srcb_d        = srcb_q;
        ctrl_d        = ctrl_q;
        owner_d       = owner_q;
        rsp0_result_d = rsp0_result_q;
        rsp0_zero_d   = rsp0_zero_q;
        rsp1_result_d = rsp1_result_q;
        rsp1_zero_d   = rsp1_zero_q;

        unique case (state_q)
            StIdle: begin
                if (req0_ready || req1_ready) begin
                    srca_d       = grant ? req1_a  : req0_a;
                    srcb_d       = grant ? req1_b  : req0_b;
                    ctrl_d       = grant ? req1_op : req0_op;
                    owner_d      = grant;
                    last_grant_d = grant;
                    cnt_d        = CntInit;
                    state_d      = StExec;
                end
            end
            StExec: begin
                if (cnt_q == 4'd0) begin
                    // Zero is taken from the ALU as-is, never recomputed here.
                    if (owner_q) begin
                        rsp1_result_d = alu_result;
                        rsp1_zero_d   = alu_zero;
                    end else begin
                        rsp0_result_d = alu_result;
                        rsp0_zero_d   = alu_zero;
                    end
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StResp: begin
                // Only the owner's ready matters; the other side is ignored.
                if (owner_q ? rsp1_ready : rsp0_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            last_grant_q  <= 1'b1;
            cnt_q         <= 4'd0;
            srca_q        <= '0;
            srcb_q        <= '0;
            ctrl_q        <= 3'd0;
            owner_q       <= 1'b0;
            rsp0_result_q <= '0;
            rsp0_zero_q   <= 1'b0;
            rsp1_result_q <= '0;
            rsp1_zero_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_grant_q  <= last_grant_d;
            cnt_q         <= cnt_d;
            srca_q        <= srca_d;
            srcb_q        <= srcb_d;
            ctrl_q        <= ctrl_d;
            owner_q       <= owner_d;
            rsp0_result_q <= rsp0_result_d;
            rsp0_zero_q   <= rsp0_zero_d;
            rsp1_result_q <= rsp1_result_d;
            rsp1_zero_q   <= rsp1_zero_d;
        end
    end

    assign alu_srca    = srca_q;
    assign alu_srcb    = srcb_q;
    assign alu_ctrl    = ctrl_q;
    assign owner       = owner_q;
    assign busy        = !idle;
    assign rsp0_valid  = (state_q == StResp) && !owner_q;
    assign rsp1_valid  = (state_q == StResp) && owner_q;
    assign rsp0_result = rsp0_result_q;
    assign rsp0_zero   = rsp0_zero_q;
    assign rsp1_result = rsp1_result_q;
    assign rsp1_zero   = rsp1_zero_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Testbench for alu_share_arbiter: one instance with EXEC_CYCLES=1 and one
// with EXEC_CYCLES=3, each driving its own behavioural ALU model.

module tb_alu_share_arbiter;

    logic clk;
    logic rst_n;

    // EXEC_CYCLES = 1 instance
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [2:0]  req0_op, req1_op;
    logic        rsp0_valid, rsp0_ready, rsp0_zero, rsp1_valid, rsp1_ready, rsp1_zero;
    logic [31:0] rsp0_result, rsp1_result;
    logic [31:0] alu_srca, alu_srcb, alu_result;
    logic [2:0]  alu_ctrl;
    logic        alu_zero, busy, owner;

    // EXEC_CYCLES = 3 instance
    logic        x_req0_valid, x_req0_ready, x_req1_ready;
    logic [31:0] x_req0_a, x_req0_b;
    logic [2:0]  x_req0_op;
    logic        x_rsp0_valid, x_rsp0_ready, x_rsp0_zero, x_rsp1_valid, x_rsp1_zero;
    logic [31:0] x_rsp0_result, x_rsp1_result;
    logic [31:0] x_alu_srca, x_alu_srcb, x_alu_result;
    logic [2:0]  x_alu_ctrl;
    logic        x_alu_zero, x_busy, x_owner;

    int pass_cnt  = 0;
    int total_cnt = 0;

    // ALU model: add, sub, and, or, slt; op 110 returns a nonzero result with
    // Zero forced high; anything else returns a marker value.
    function automatic logic [32:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                              input logic [2:0] op);
        logic [31:0] r;
        logic        z;
        case (op)
            3'b000:  r = a + b;
            3'b001:  r = a - b;
            3'b010:  r = a & b;
            3'b011:  r = a | b;
            3'b101:  r = {31'd0, $signed(a) < $signed(b)};
            3'b110:  r = 32'h0000_0040;
            default: r = 32'hDEAD_BEEF;
        endcase
        z = (op == 3'b110) ? 1'b1 : (r == 32'd0);
        return {z, r};
    endfunction

    always_comb {alu_zero, alu_result}     = alu_model(alu_srca, alu_srcb, alu_ctrl);
    always_comb {x_alu_zero, x_alu_result} = alu_model(x_alu_srca, x_alu_srcb, x_alu_ctrl);

    alu_share_arbiter #(.WIDTH(32), .EXEC_CYCLES(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp0_result(rsp0_result), .rsp0_zero(rsp0_zero),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp1_result(rsp1_result), .rsp1_zero(rsp1_zero),
        .alu_srca(alu_srca), .alu_srcb(alu_srcb), .alu_ctrl(alu_ctrl),
        .alu_result(alu_result), .alu_zero(alu_zero),
        .busy(busy), .owner(owner)
    );

    alu_share_arbiter #(.WIDTH(32), .EXEC_CYCLES(3)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(x_req0_valid), .req0_ready(x_req0_ready),
        .req0_a(x_req0_a), .req0_b(x_req0_b), .req0_op(x_req0_op),
        .req1_valid(1'b0), .req1_ready(x_req1_ready),
        .req1_a(32'd0), .req1_b(32'd0), .req1_op(3'd0),
        .rsp0_valid(x_rsp0_valid), .rsp0_ready(x_rsp0_ready),
        .rsp0_result(x_rsp0_result), .rsp0_zero(x_rsp0_zero),
        .rsp1_valid(x_rsp1_valid), .rsp1_ready(1'b1),
        .rsp1_result(x_rsp1_result), .rsp1_zero(x_rsp1_zero),
        .alu_srca(x_alu_srca), .alu_srcb(x_alu_srcb), .alu_ctrl(x_alu_ctrl),
        .alu_result(x_alu_result), .alu_zero(x_alu_zero),
        .busy(x_busy), .owner(x_owner)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive_req(input logic sel, input logic v, input logic [31:0] a,
                             input logic [31:0] b, input logic [2:0] op);
        if (sel) begin
            req1_valid = v; req1_a = a; req1_b = b; req1_op = op;
        end else begin
            req0_valid = v; req0_a = a; req0_b = b; req0_op = op;
        end
    endtask

    typedef struct {
        logic        sel;
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;
        logic [31:0] res;
        logic        zero;
    } vec_t;

    vec_t vecs[7];

    // Single isolated transaction with both response readies high.
    task automatic run_vec(input vec_t v);
        @(posedge clk); #1;
        drive_req(v.sel, 1'b1, v.a, v.b, v.op);
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        @(negedge clk);                                   // cycle T
        chk("vec ready", v.sel ? req1_ready : req0_ready, 1);
        chk("vec idle busy", busy, 0);
        @(posedge clk); #1;
        drive_req(v.sel, 1'b0, 32'd0, 32'd0, 3'd0);
        @(negedge clk);                                   // T+1
        chk("vec exec busy", busy, 1);
        chk("vec srca", alu_srca, v.a);
        chk("vec srcb", alu_srcb, v.b);
        chk("vec ctrl", alu_ctrl, v.op);
        chk("vec owner", owner, v.sel);
        chk("vec exec no rsp", rsp0_valid | rsp1_valid, 0);
        @(negedge clk);                                   // T+2
        chk("vec rsp valid", v.sel ? rsp1_valid : rsp0_valid, 1);
        chk("vec other rsp", v.sel ? rsp0_valid : rsp1_valid, 0);
        chk("vec result", v.sel ? rsp1_result : rsp0_result, v.res);
        chk("vec zero", v.sel ? rsp1_zero : rsp0_zero, v.zero);
        @(negedge clk);                                   // T+3
        chk("vec consumed", rsp0_valid | rsp1_valid | busy, 0);
        chk("vec result held", v.sel ? rsp1_result : rsp0_result, v.res);
    endtask

    initial begin
        int g;
        int r;

        vecs[0] = '{1'b0, 32'd5,          32'd7, 3'b000, 32'd12,          1'b0};
        vecs[1] = '{1'b1, 32'd9,          32'd9, 3'b001, 32'd0,           1'b1};
        vecs[2] = '{1'b0, 32'hFFFF_FFFF,  32'd1, 3'b000, 32'd0,           1'b1};
        vecs[3] = '{1'b1, 32'hFFFF_FFFE,  32'd5, 3'b101, 32'd1,           1'b0};
        vecs[4] = '{1'b0, 32'd1,          32'd2, 3'b100, 32'hDEAD_BEEF,   1'b0};
        vecs[5] = '{1'b1, 32'd7,          32'd3, 3'b110, 32'h0000_0040,   1'b1};
        vecs[6] = '{1'b0, 32'd8,          32'd3, 3'b010, 32'd0,           1'b1};

        rst_n = 1'b0;
        req0_valid = 0; req0_a = 0; req0_b = 0; req0_op = 0;
        req1_valid = 0; req1_a = 0; req1_b = 0; req1_op = 0;
        rsp0_ready = 0; rsp1_ready = 0;
        x_req0_valid = 0; x_req0_a = 0; x_req0_b = 0; x_req0_op = 0; x_rsp0_ready = 0;

        // Reset state
        @(negedge clk);
        chk("rst busy", busy, 0);
        chk("rst owner", owner, 0);
        chk("rst ready", {30'd0, req0_ready, req1_ready}, 0);
        chk("rst rsp valid", {30'd0, rsp0_valid, rsp1_valid}, 0);
        chk("rst alu srca", alu_srca, 0);
        chk("rst alu ctrl", alu_ctrl, 0);
        chk("rst rsp0 result", rsp0_result, 0);
        chk("rst x busy", x_busy, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Table-driven single transactions
        for (int i = 0; i < 7; i++) begin
            run_vec(vecs[i]);
        end

        // Round-robin from reset with both requesters continuously valid
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        drive_req(1'b0, 1'b1, 32'd3, 32'd1, 3'b010);
        drive_req(1'b1, 1'b1, 32'd3, 32'd1, 3'b011);
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            g = -1;
            for (int c = 0; c < 10 && g < 0; c++) begin
                @(negedge clk);
                chk("rr one ready", req0_ready & req1_ready, 0);
                if (req0_ready) g = 0;
                else if (req1_ready) g = 1;
            end
            chk("rr grant", g, i % 2);
            r = -1;
            for (int c = 0; c < 10 && r < 0; c++) begin
                @(negedge clk);
                if (rsp0_valid) r = 0;
                else if (rsp1_valid) r = 1;
            end
            chk("rr rsp owner", r, i % 2);
            chk("rr result", (i % 2) ? rsp1_result : rsp0_result, (i % 2) ? 3 : 1);
        end
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;

        // Backpressure on rsp0 with req1 waiting and a non-owner rsp1_ready
        @(posedge clk); #1;
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b1;
        drive_req(1'b0, 1'b1, 32'd5, 32'd7, 3'b000);
        @(negedge clk);
        chk("bp ready0", req0_ready, 1);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        drive_req(1'b1, 1'b1, 32'd3, 32'd1, 3'b011);
        @(negedge clk);
        chk("bp exec ready1", req1_ready, 0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("bp rsp0 valid", rsp0_valid, 1);
            chk("bp rsp0 result", rsp0_result, 12);
            chk("bp rsp1 valid", rsp1_valid, 0);
            chk("bp ready1 held off", req1_ready, 0);
        end
        @(posedge clk); #1;
        rsp0_ready = 1'b1;
        @(negedge clk);
        chk("bp still valid", rsp0_valid, 1);
        @(negedge clk);
        chk("bp released", rsp0_valid, 0);
        chk("bp ready1", req1_ready, 1);
        chk("bp result kept", rsp0_result, 12);
        @(posedge clk); #1;
        req1_valid = 1'b0;
        r = -1;
        for (int c = 0; c < 10 && r < 0; c++) begin
            @(negedge clk);
            if (rsp1_valid) r = 1;
        end
        chk("bp rsp1 arrives", r, 1);
        chk("bp rsp1 result", rsp1_result, 3);

        // EXEC_CYCLES = 3: operands held three cycles, response at T+4
        @(posedge clk); #1;
        x_req0_valid = 1'b1; x_req0_a = 32'hFFFF_FFFF; x_req0_b = 32'd1; x_req0_op = 3'b000;
        x_rsp0_ready = 1'b1;
        @(negedge clk);
        chk("x3 ready", x_req0_ready, 1);
        @(posedge clk); #1;
        x_req0_valid = 1'b0; x_req0_a = 32'h1234_5678; x_req0_b = 32'd9; x_req0_op = 3'b011;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("x3 srca stable", x_alu_srca, 32'hFFFF_FFFF);
            chk("x3 srcb stable", x_alu_srcb, 32'd1);
            chk("x3 busy", x_busy, 1);
            chk("x3 no early rsp", x_rsp0_valid, 0);
        end
        @(negedge clk);
        chk("x3 rsp valid", x_rsp0_valid, 1);
        chk("x3 result", x_rsp0_result, 0);
        chk("x3 zero", x_rsp0_zero, 1);
        @(negedge clk);
        chk("x3 done", x_busy, 0);

        // Reset asserted during EXEC
        @(posedge clk); #1;
        drive_req(1'b0, 1'b1, 32'd5, 32'd7, 3'b000);
        rsp0_ready = 1'b1;
        @(posedge clk); #1;
        req0_valid = 1'b0;
        #2;
        chk("mid exec busy", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("mid rst busy", busy, 0);
        chk("mid rst srca", alu_srca, 0);
        chk("mid rst owner", owner, 0);
        chk("mid rst rsp0 result", rsp0_result, 0);
        chk("mid rst rsp1 result", rsp1_result, 0);
        chk("mid rst x zero", x_rsp0_zero, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        drive_req(1'b0, 1'b1, 32'd2, 32'd2, 3'b000);
        drive_req(1'b1, 1'b1, 32'd9, 32'd9, 3'b001);
        @(negedge clk);
        chk("post rst ready0", req0_ready, 1);
        chk("post rst ready1", req1_ready, 0);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(negedge clk);
        chk("post rst no stale", rsp0_valid | rsp1_valid, 0);
        @(negedge clk);
        chk("post rst rsp0", rsp0_valid, 1);
        chk("post rst rsp1", rsp1_valid, 0);
        chk("post rst result", rsp0_result, 4);

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
